// File: rtl/mmu_kt22_if.sv
// mmu_kt22_if: CPU-side translation request/response bundle for mmu_kt22.
//   req_valid/req_ready  request handshake (accepted when both high at a clock edge)
//   req_va               16-bit virtual address
//   req_cm               access mode: 00 kernel, 01 supervisor, 11 user (10 is illegal)
//   req_wr               1 write, 0 read
//   req_i                1 instruction-space access
//   rsp_valid            one-cycle pulse, one cycle after an accepted request
//   rsp_pa               22-bit physical address
//   rsp_abort            access must be aborted
//   rsp_trap             memory-management trap after the access completes
// master = CPU side, slave = MMU side.
interface mmu_kt22_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_va;
    logic [1:0]  req_cm;
    logic        req_wr;
    logic        req_i;
    logic        rsp_valid;
    logic [21:0] rsp_pa;
    logic        rsp_abort;
    logic        rsp_trap;

    modport master (
        output req_valid, req_va, req_cm, req_wr, req_i,
        input  req_ready, rsp_valid, rsp_pa, rsp_abort, rsp_trap
    );

    modport slave (
        input  req_valid, req_va, req_cm, req_wr, req_i,
        output req_ready, rsp_valid, rsp_pa, rsp_abort, rsp_trap
    );
endinterface

// File: rtl/mmu_kt22.sv
// mmu_kt22: KT-11 style memory management unit with 18/22-bit mapping, split I/D
// spaces, MMR0 abort freeze and MMR1 register-update logging. Translation is done
// combinationally from the request and registered into a one-deep response stage.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   soft_reset        sync clear of MMR0 and MMR3 (RESET instruction)
//   bus               mmu_kt22_if.slave request/response bundle
//   fetch_va          instruction fetch start: loads MMR2 (with accepted req), clears MMR1
//   rn_upd/num/delta  GPR auto-inc/dec event logged into MMR1
//   pxr_*             register-file access; address {mmr,par,mode[1:0],D,apf[2:0]},
//                     MMR select in [1:0] when mmr=1; ack and read data one cycle later
module mmu_kt22 #(
    parameter int MAP22_EN = 1,
    parameter int PAR_BITS = 16,
    parameter int NUM_ID   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        soft_reset,
    mmu_kt22_if.slave   bus,
    input  logic        fetch_va,
    input  logic        rn_upd,
    input  logic [2:0]  rn_num,
    input  logic [4:0]  rn_delta,
    input  logic        pxr_wr,
    input  logic        pxr_rd,
    input  logic [1:0]  pxr_be,
    input  logic [7:0]  pxr_addr,
    input  logic [15:0] pxr_data_in,
    output logic [15:0] pxr_data_out,
    output logic        pxr_ack
);

    localparam logic [15:0] PAR_MASK   = 16'((32'd1 << PAR_BITS) - 32'd1);
    localparam logic [15:0] PDR_WMASK  = 16'o077417;
    localparam logic [15:0] MMR0_WMASK = 16'o171177;
    localparam logic [15:0] MMR3_WMASK = {11'b0, MAP22_EN != 0, 1'b0, {3{NUM_ID == 2}}};

    // Written byte lanes take din & mask; bits outside the mask read back as 0.
    function automatic logic [15:0] byte_wr(input logic [15:0] old_v, input logic [15:0] din,
                                            input logic [15:0] mask, input logic [1:0] be);
        logic [15:0] lanes;
        lanes = {{8{be[1]}}, {8{be[0]}}};
        return (old_v & ~lanes) | (din & mask & lanes);
    endfunction

    logic [15:0] par_q [64];
    logic [15:0] pdr_q [64];

    logic [15:0] mmr0_q, mmr0_d;
    logic [15:0] mmr1_q, mmr1_d;
    logic [15:0] mmr2_q, mmr2_d;
    logic [15:0] mmr3_q, mmr3_d;
    logic [1:0]  mmr1_cnt_q, mmr1_cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [21:0] rsp_pa_q, rsp_pa_d;
    logic        rsp_abort_q, rsp_abort_d;
    logic        rsp_trap_q, rsp_trap_d;
    logic        pxr_ack_q, pxr_ack_d;
    logic [15:0] pxr_data_q, pxr_data_d;

    // register-file decode
    logic        pxr_is_mmr, pxr_is_par, pxr_impl;
    logic [5:0]  pxr_idx;
    logic [1:0]  pxr_sel;
    logic        pdr_sw_wr, par_sw_wr, mmr0_sw_wr, mmr3_sw_wr;
    logic        req_ready;
    logic [15:0] rd_data;

    assign pxr_is_mmr = pxr_addr[7];
    assign pxr_is_par = pxr_addr[6];
    assign pxr_idx    = pxr_addr[5:0];
    assign pxr_sel    = pxr_addr[1:0];
    assign pxr_impl   = (NUM_ID == 2) || !pxr_addr[3];
    assign pdr_sw_wr  = pxr_wr && !pxr_is_mmr && !pxr_is_par && pxr_impl;
    assign par_sw_wr  = pxr_wr && !pxr_is_mmr &&  pxr_is_par && pxr_impl;
    assign mmr0_sw_wr = pxr_wr && pxr_is_mmr && (pxr_sel == 2'd0);
    assign mmr3_sw_wr = pxr_wr && pxr_is_mmr && (pxr_sel == 2'd3);

    // A PDR or MMR0 write would race the response-edge update, so stall requests.
    assign req_ready  = !(pxr_wr && ((!pxr_is_mmr && !pxr_is_par) ||
                                     (pxr_is_mmr && (pxr_sel == 2'd0))));

    // translation
    logic        d_en, d_sel;
    logic [5:0]  tidx;
    logic [15:0] par_v, pdr_v;
    logic [2:0]  acf;
    logic [6:0]  bn, plf;
    logic        ed, map_en, mode22, frozen, req_acc;
    logic [21:0] sum22, pa;
    logic        err_nr, err_ple, err_ro, abort, trap_cond, trap;
    logic        upd_we;
    logic [15:0] upd_data;

    always_comb begin
        d_en = 1'b0;
        case (bus.req_cm)
            2'b00:   d_en = mmr3_q[2];
            2'b01:   d_en = mmr3_q[1];
            2'b11:   d_en = mmr3_q[0];
            default: d_en = 1'b0;
        endcase
    end

    assign d_sel   = (NUM_ID == 2) && d_en && !bus.req_i;
    assign tidx    = {bus.req_cm, d_sel, bus.req_va[15:13]};
    assign par_v   = par_q[tidx] & PAR_MASK;
    assign pdr_v   = pdr_q[tidx];
    assign acf     = pdr_v[2:0];
    assign ed      = pdr_v[3];
    assign plf     = pdr_v[14:8];
    assign bn      = bus.req_va[12:6];
    assign map_en  = mmr0_q[0];
    assign mode22  = (MAP22_EN != 0) && mmr3_q[4];
    assign frozen  = |mmr0_q[15:13];
    assign req_acc = bus.req_valid && req_ready;
    assign sum22   = {par_v, 6'b0} + {9'b0, bus.req_va[12:0]};

    always_comb begin
        pa = {6'b0, bus.req_va};
        if (!map_en) begin
            if (bus.req_va[15:13] == 3'b111) pa = {6'h3F, bus.req_va};
        end else if (mode22) begin
            pa = sum22;
        end else begin
            pa = {4'h0, sum22[17:0]};
            if (sum22[17:13] == 5'h1F) pa[21:18] = 4'hF;
        end
    end

    assign err_nr    = map_en && ((acf == 3'd0) || (acf == 3'd3) || (acf == 3'd7) ||
                                  (bus.req_cm == 2'b10));
    assign err_ple   = map_en && (ed ? (bn < plf) : (bn > plf));
    assign err_ro    = map_en && bus.req_wr && ((acf == 3'd1) || (acf == 3'd2));
    assign abort     = err_nr || err_ple || err_ro;
    assign trap_cond = map_en && !abort &&
                       ((acf == 3'd1) || (acf == 3'd4) || ((acf == 3'd5) && bus.req_wr));
    assign trap      = trap_cond && mmr0_q[9];

    // A (bit 7) on trap condition, W (bit 6) on completed write.
    assign upd_we   = req_acc && map_en && !abort && (trap_cond || bus.req_wr);
    assign upd_data = pdr_v | {8'b0, trap_cond, bus.req_wr, 6'b0};

    always_comb begin
        rd_data = 16'h0;
        if (pxr_is_mmr) begin
            case (pxr_sel)
                2'd0:    rd_data = mmr0_q;
                2'd1:    rd_data = mmr1_q;
                2'd2:    rd_data = mmr2_q;
                default: rd_data = mmr3_q;
            endcase
        end else if (pxr_impl) begin
            rd_data = pxr_is_par ? (par_q[pxr_idx] & PAR_MASK) : pdr_q[pxr_idx];
        end
    end

    always_comb begin
        mmr0_d = mmr0_q;
        if (req_acc && abort && !frozen) begin
            mmr0_d[15:13] = {err_nr, err_ple, err_ro};
            mmr0_d[6:1]   = tidx;
        end
        if (req_acc && trap) mmr0_d[12] = 1'b1;
        if (mmr0_sw_wr) mmr0_d = byte_wr(mmr0_q, pxr_data_in, MMR0_WMASK, pxr_be);
        if (soft_reset) mmr0_d = 16'h0;
    end

    always_comb begin
        mmr3_d = mmr3_q;
        if (mmr3_sw_wr) mmr3_d = byte_wr(mmr3_q, pxr_data_in, MMR3_WMASK, pxr_be);
        if (soft_reset) mmr3_d = 16'h0;
    end

    // MMR1 takes the first two register updates after a fetch; later ones are dropped.
    always_comb begin
        mmr1_d     = mmr1_q;
        mmr1_cnt_d = mmr1_cnt_q;
        mmr2_d     = mmr2_q;
        if (!frozen) begin
            if (fetch_va) begin
                mmr1_d     = 16'h0;
                mmr1_cnt_d = 2'd0;
                if (req_acc) mmr2_d = bus.req_va;
            end
            if (rn_upd) begin
                case (mmr1_cnt_d)
                    2'd0: begin
                        mmr1_d[7:0] = {rn_delta, rn_num};
                        mmr1_cnt_d  = 2'd1;
                    end
                    2'd1: begin
                        mmr1_d[15:8] = {rn_delta, rn_num};
                        mmr1_cnt_d   = 2'd2;
                    end
                    default: mmr1_cnt_d = mmr1_cnt_d;
                endcase
            end
        end
    end

    always_comb begin
        rsp_valid_d = req_acc;
        rsp_pa_d    = req_acc ? pa : rsp_pa_q;
        rsp_abort_d = req_acc && abort;
        rsp_trap_d  = req_acc && trap;
        pxr_ack_d   = pxr_rd || pxr_wr;
        pxr_data_d  = pxr_rd ? rd_data : pxr_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mmr0_q      <= 16'h0;
            mmr1_q      <= 16'h0;
            mmr2_q      <= 16'h0;
            mmr3_q      <= 16'h0;
            mmr1_cnt_q  <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_pa_q    <= 22'h0;
            rsp_abort_q <= 1'b0;
            rsp_trap_q  <= 1'b0;
            pxr_ack_q   <= 1'b0;
            pxr_data_q  <= 16'h0;
        end else begin
            mmr0_q      <= mmr0_d;
            mmr1_q      <= mmr1_d;
            mmr2_q      <= mmr2_d;
            mmr3_q      <= mmr3_d;
            mmr1_cnt_q  <= mmr1_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_pa_q    <= rsp_pa_d;
            rsp_abort_q <= rsp_abort_d;
            rsp_trap_q  <= rsp_trap_d;
            pxr_ack_q   <= pxr_ack_d;
            pxr_data_q  <= pxr_data_d;
        end
    end

    // PAR/PDR contents survive reset; a software PDR write overrides a same-edge update.
    always_ff @(posedge clk) begin
        if (upd_we) pdr_q[tidx] <= upd_data;
        if (pdr_sw_wr) pdr_q[pxr_idx] <= byte_wr(pdr_q[pxr_idx], pxr_data_in, PDR_WMASK, pxr_be);
        if (par_sw_wr) par_q[pxr_idx] <= byte_wr(par_q[pxr_idx], pxr_data_in, PAR_MASK, pxr_be);
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_pa     = rsp_pa_q;
    assign bus.rsp_abort  = rsp_abort_q;
    assign bus.rsp_trap   = rsp_trap_q;
    assign pxr_ack        = pxr_ack_q;
    assign pxr_data_out   = pxr_data_q;

endmodule

// File: tb/tb_mmu_kt22.sv
// tb_mmu_kt22: directed-vector bench for mmu_kt22 with hand-computed expectations.
module tb_mmu_kt22;
    logic        clk = 1'b0;
    logic        reset_n, soft_reset, fetch_va, rn_upd;
    logic [2:0]  rn_num;
    logic [4:0]  rn_delta;
    logic        pxr_wr, pxr_rd;
    logic [1:0]  pxr_be;
    logic [7:0]  pxr_addr;
    logic [15:0] pxr_data_in, pxr_data_out;
    logic        pxr_ack;
    logic [15:0] rd;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mmu_kt22_if bus();

    mmu_kt22 #(.MAP22_EN(1), .PAR_BITS(16), .NUM_ID(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .soft_reset   (soft_reset),
        .bus          (bus),
        .fetch_va     (fetch_va),
        .rn_upd       (rn_upd),
        .rn_num       (rn_num),
        .rn_delta     (rn_delta),
        .pxr_wr       (pxr_wr),
        .pxr_rd       (pxr_rd),
        .pxr_be       (pxr_be),
        .pxr_addr     (pxr_addr),
        .pxr_data_in  (pxr_data_in),
        .pxr_data_out (pxr_data_out),
        .pxr_ack      (pxr_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pdr_a(input logic [1:0] m, input logic d, input logic [2:0] apf);
        return {2'b00, m, d, apf};
    endfunction

    function automatic logic [7:0] par_a(input logic [1:0] m, input logic d, input logic [2:0] apf);
        return {2'b01, m, d, apf};
    endfunction

    function automatic logic [7:0] mmr_a(input logic [1:0] sel);
        return {6'b100000, sel};
    endfunction

    task automatic pwrb(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
        @(negedge clk);
        pxr_wr = 1'b1; pxr_addr = a; pxr_data_in = d; pxr_be = be;
        @(posedge clk); #1;
        pxr_wr = 1'b0; pxr_be = 2'b00;
    endtask

    task automatic pwr(input logic [7:0] a, input logic [15:0] d);
        pwrb(a, d, 2'b11);
    endtask

    task automatic prd(input logic [7:0] a, output logic [15:0] d);
        @(negedge clk);
        pxr_rd = 1'b1; pxr_addr = a;
        @(posedge clk); #1;
        pxr_rd = 1'b0;
        d = pxr_data_out;
    endtask

    task automatic req(input logic [15:0] va, input logic [1:0] cm, input logic wr,
                       input logic isp, input logic fv, input logic sr);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_va = va; bus.req_cm = cm;
        bus.req_wr = wr; bus.req_i = isp; fetch_va = fv; soft_reset = sr;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; fetch_va = 1'b0; soft_reset = 1'b0;
    endtask

    task automatic rn(input logic [2:0] num, input logic [4:0] delta);
        @(negedge clk);
        rn_upd = 1'b1; rn_num = num; rn_delta = delta;
        @(posedge clk); #1;
        rn_upd = 1'b0;
    endtask

    task automatic fetch_pulse();
        @(negedge clk);
        fetch_va = 1'b1;
        @(posedge clk); #1;
        fetch_va = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; soft_reset = 1'b0; fetch_va = 1'b0; rn_upd = 1'b0;
        rn_num = '0; rn_delta = '0; pxr_wr = 1'b0; pxr_rd = 1'b0; pxr_be = '0;
        pxr_addr = '0; pxr_data_in = '0;
        bus.req_valid = 1'b0; bus.req_va = '0; bus.req_cm = '0; bus.req_wr = 1'b0; bus.req_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_pxr_ack", pxr_ack, 0);
        check("rst_pxr_data", pxr_data_out, 0);
        @(negedge clk) reset_n = 1'b1;

        prd(mmr_a(0), rd); check("rst_mmr0", rd, 0);
        check("rd_ack", pxr_ack, 1);
        prd(mmr_a(3), rd); check("rst_mmr3", rd, 0);

        // unmapped
        req(16'o123456, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("unmap_valid", bus.rsp_valid, 1);
        check("unmap_pa", bus.rsp_pa, 22'o123456);
        check("unmap_abort", bus.rsp_abort, 0);

        // basic kernel mapping
        pwr(par_a(2'b00, 1'b0, 3'd0), 16'o001000);
        pwr(pdr_a(2'b00, 1'b0, 3'd0), 16'o077406);
        pwr(mmr_a(0), 16'o000001);
        prd(pdr_a(2'b00, 1'b0, 3'd0), rd); check("kpdr0_rb", rd, 16'o077406);
        req(16'o000100, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        check("map_valid", bus.rsp_valid, 1);
        check("map_pa", bus.rsp_pa, 22'o100100);
        check("map_abort", bus.rsp_abort, 0);
        check("map_trap", bus.rsp_trap, 0);
        prd(mmr_a(2), rd); check("mmr2_load", rd, 16'o000100);

        // 22-bit versus 18-bit with I/O page relocation
        pwr(par_a(2'b00, 1'b0, 3'd0), 16'o007777);
        pwr(mmr_a(3), 16'o000020);
        req(16'o000076, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pa22", bus.rsp_pa, 22'o0777776);
        pwr(par_a(2'b00, 1'b0, 3'd1), 16'o177000);
        pwr(pdr_a(2'b00, 1'b0, 3'd1), 16'o077406);
        req(16'o020100, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pa22_hi", bus.rsp_pa, 22'o17700100);
        pwr(mmr_a(3), 16'o000000);
        req(16'o000076, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pa18_io", bus.rsp_pa, 22'o17777776);

        // byte enables
        pwr(par_a(2'b00, 1'b0, 3'd3), 16'o123456);
        pwrb(par_a(2'b00, 1'b0, 3'd3), 16'o000000, 2'b01);
        prd(par_a(2'b00, 1'b0, 3'd3), rd); check("be_lo", rd, 16'o123400);
        pwrb(par_a(2'b00, 1'b0, 3'd3), 16'o000000, 2'b00);
        prd(par_a(2'b00, 1'b0, 3'd3), rd); check("be_none", rd, 16'o123400);

        // MMR1 logging
        fetch_pulse();
        rn(3'd2, 5'd2);
        rn(3'd6, 5'b11110);
        rn(3'd1, 5'd1);
        prd(mmr_a(1), rd); check("mmr1_two", rd, 16'o173022);
        fetch_pulse();
        prd(mmr_a(1), rd); check("mmr1_clr", rd, 16'o000000);
        rn(3'd2, 5'd2);

        // read-only abort then freeze
        pwr(par_a(2'b11, 1'b0, 3'd3), 16'o002000);
        pwr(pdr_a(2'b11, 1'b0, 3'd3), 16'o077402);
        pwr(pdr_a(2'b11, 1'b0, 3'd4), 16'o077400);
        req(16'o060000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ro_abort", bus.rsp_abort, 1);
        prd(mmr_a(0), rd); check("ro_mmr0", rd, 16'o020147);
        req(16'o100000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        check("nr_abort", bus.rsp_abort, 1);
        prd(mmr_a(0), rd); check("frozen_mmr0", rd, 16'o020147);
        req(16'o000200, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        rn(3'd5, 5'd1);
        prd(mmr_a(1), rd); check("frozen_mmr1", rd, 16'o000022);
        prd(mmr_a(2), rd); check("frozen_mmr2", rd, 16'o000100);
        pwr(mmr_a(0), 16'o000001);
        prd(mmr_a(0), rd); check("unfreeze", rd, 16'o000001);

        // traps and A/W bits
        pwr(mmr_a(0), 16'o001001);
        pwr(par_a(2'b11, 1'b0, 3'd5), 16'o003000);
        pwr(pdr_a(2'b11, 1'b0, 3'd5), 16'o077405);
        req(16'o120000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        check("acf5_rd_trap", bus.rsp_trap, 0);
        prd(pdr_a(2'b11, 1'b0, 3'd5), rd); check("acf5_rd_pdr", rd, 16'o077405);
        req(16'o120000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        check("acf5_wr_trap", bus.rsp_trap, 1);
        check("acf5_wr_pa", bus.rsp_pa, 22'o300000);
        prd(pdr_a(2'b11, 1'b0, 3'd5), rd); check("acf5_wr_pdr", rd, 16'o077705);
        prd(mmr_a(0), rd); check("trap_mmr0", rd, 16'o011001);
        req(16'o000100, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        prd(pdr_a(2'b00, 1'b0, 3'd0), rd); check("w_bit", rd, 16'o077506);

        // page length errors
        pwr(mmr_a(0), 16'o000001);
        pwr(par_a(2'b00, 1'b0, 3'd2), 16'o004000);
        pwr(pdr_a(2'b00, 1'b0, 3'd2), 16'o004016);
        req(16'o040700, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ple_ed1", bus.rsp_abort, 1);
        prd(mmr_a(0), rd); check("ple_mmr0", rd, 16'o040005);
        pwr(mmr_a(0), 16'o000001);
        pwr(pdr_a(2'b00, 1'b0, 3'd2), 16'o004006);
        req(16'o041100, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ple_ed0", bus.rsp_abort, 1);
        pwr(mmr_a(0), 16'o000001);
        req(16'o041000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ple_edge_ok", bus.rsp_abort, 0);
        check("ple_edge_pa", bus.rsp_pa, 22'o401000);

        // req_ready stalls only for PDR/MMR0 writes
        @(negedge clk);
        check("rdy_idle", bus.req_ready, 1);
        pxr_wr = 1'b1; pxr_addr = pdr_a(2'b00, 1'b0, 3'd2); pxr_data_in = 16'o004006; pxr_be = 2'b11;
        #1 check("rdy_pdr_wr", bus.req_ready, 0);
        @(negedge clk);
        pxr_addr = par_a(2'b00, 1'b0, 3'd2); pxr_data_in = 16'o004000;
        #1 check("rdy_par_wr", bus.req_ready, 1);
        @(negedge clk);
        pxr_addr = mmr_a(0); pxr_data_in = 16'o000001;
        #1 check("rdy_mmr0_wr", bus.req_ready, 0);
        @(negedge clk);
        pxr_wr = 1'b0; pxr_be = 2'b00;

        // split I/D
        pwr(par_a(2'b00, 1'b1, 3'd0), 16'o002000);
        pwr(pdr_a(2'b00, 1'b1, 3'd0), 16'o077406);
        pwr(mmr_a(3), 16'o000004);
        req(16'o000100, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("dspace_pa", bus.rsp_pa, 22'o200100);
        req(16'o000100, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ispace_pa", bus.rsp_pa, 22'o000000);

        // soft reset with a request in the same cycle
        pwr(mmr_a(3), 16'o000020);
        req(16'o000100, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        check("sr_valid", bus.rsp_valid, 1);
        check("sr_pa", bus.rsp_pa, 22'o1000000);
        prd(mmr_a(0), rd); check("sr_mmr0", rd, 0);
        prd(mmr_a(3), rd); check("sr_mmr3", rd, 0);

        // hard reset during a request drops the response
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_va = 16'o000100; bus.req_cm = 2'b00; bus.req_wr = 1'b0;
        #2 reset_n = 1'b0;
        @(posedge clk); #1;
        check("hr_drop", bus.rsp_valid, 0);
        check("hr_pxr_data", pxr_data_out, 0);
        bus.req_valid = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        prd(mmr_a(1), rd); check("hr_mmr1", rd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
